// File: rtl/xalu_pkg.sv
// rtl/xalu_pkg.sv - shared multiply/divide unit types and constants
package xalu_pkg;

  // Divider sequencing states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIX  = 2'd2
  } div_state_t;

  localparam int XALU_WIDTH = 32;

  // Quotient produced by the restoring datapath for a non-negative dividend over zero
  localparam logic [XALU_WIDTH-1:0] DIV0_QUOT = '1;

endpackage

// File: rtl/radix2_divider.sv
// rtl/radix2_divider.sv - iterative radix-2 restoring divider on a tvalid/tready stream
module radix2_divider
  import xalu_pkg::*;
#(
  parameter int SIGNED = 1,
  parameter int WIDTH  = XALU_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s_axis_dividend_tvalid,
  input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
  output logic               s_axis_dividend_tready,
  input  logic               s_axis_divisor_tvalid,
  input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
  output logic               s_axis_divisor_tready,
  output logic               m_axis_dout_tvalid,
  output logic [2*WIDTH-1:0] m_axis_dout_tdata
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  div_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]     rem_q, rem_d;      // partial remainder, one guard bit
  logic [WIDTH-1:0]   dvd_q, dvd_d;      // dividend magnitude, shifts out as quotient shifts in
  logic [WIDTH-1:0]   dvs_q, dvs_d;      // divisor magnitude
  logic               sa_q, sa_d;
  logic               sb_q, sb_d;
  logic [2*WIDTH-1:0] dout_q, dout_d;
  logic               vld_q, vld_d;

  logic               accept;
  logic               a_neg, b_neg;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     trial;
  logic               qbit;
  logic [WIDTH-1:0]   q_fix, r_fix;

  assign s_axis_dividend_tready = (state_q == IDLE);
  assign s_axis_divisor_tready  = (state_q == IDLE);
  assign m_axis_dout_tvalid     = vld_q;
  assign m_axis_dout_tdata      = dout_q;

  // Next-state, datapath step and result formatting
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    dout_d  = dout_q;
    vld_d   = 1'b0;

    accept = s_axis_dividend_tready && s_axis_dividend_tvalid && s_axis_divisor_tvalid;
    a_neg  = (SIGNED != 0) && s_axis_dividend_tdata[WIDTH-1];
    b_neg  = (SIGNED != 0) && s_axis_divisor_tdata[WIDTH-1];

    // The guard bit of rem_q is always clear between iterations, so the shift drops nothing
    rem_shift = (rem_q << 1) | {{WIDTH{1'b0}}, dvd_q[WIDTH-1]};
    trial     = rem_shift - {1'b0, dvs_q};
    qbit      = ~trial[WIDTH];

    q_fix = (sa_q ^ sb_q) ? -dvd_q : dvd_q;
    r_fix = sa_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

    case (state_q)
      IDLE: begin
        if (accept) begin
          sa_d    = a_neg;
          sb_d    = b_neg;
          dvd_d   = a_neg ? -s_axis_dividend_tdata : s_axis_dividend_tdata;
          dvs_d   = b_neg ? -s_axis_divisor_tdata : s_axis_divisor_tdata;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = DIV;
        end
      end
      DIV: begin
        rem_d = qbit ? trial : rem_shift;
        dvd_d = {dvd_q[WIDTH-2:0], qbit};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = FIX;
        end
      end
      FIX: begin
        dout_d  = {q_fix, r_fix};
        vld_d   = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
    end
  end

endmodule

// File: tb/tb_radix2_divider.sv
// tb/tb_radix2_divider.sv - scoreboard bench for unsigned and signed divider instances
module tb_radix2_divider;
  import xalu_pkg::*;

  localparam int W   = XALU_WIDTH;
  localparam int LAT = W + 1;

  typedef struct {
    logic [2*W-1:0] data;
    int             cyc;
  } exp_t;

  typedef struct {
    int             u;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp;
  } vec_t;

  // unit 0 is SIGNED=0, unit 1 is SIGNED=1
  vec_t vecs [13] = '{
    '{0, 32'd100,        32'd7,        {32'h0000000E, 32'h00000002}},
    '{0, 32'd5,          32'd0,        {DIV0_QUOT,    32'h00000005}},
    '{0, 32'hFFFFFFFF,   32'd1,        {32'hFFFFFFFF, 32'h00000000}},
    '{0, 32'hFFFFFFFF,   32'h10,       {32'h0FFFFFFF, 32'h0000000F}},
    '{0, 32'd7,          32'd100,      {32'h00000000, 32'h00000007}},
    '{0, 32'h80000000,   32'hFFFFFFFF, {32'h00000000, 32'h80000000}},
    '{1, 32'hFFFFFFF9,   32'd2,        {32'hFFFFFFFD, 32'hFFFFFFFF}},
    '{1, 32'd7,          32'hFFFFFFFE, {32'hFFFFFFFD, 32'h00000001}},
    '{1, 32'hFFFFFFF9,   32'hFFFFFFFE, {32'h00000003, 32'hFFFFFFFF}},
    '{1, 32'h80000000,   32'hFFFFFFFF, {32'h80000000, 32'h00000000}},
    '{1, 32'hFFFFFFFB,   32'd0,        {32'h00000001, 32'hFFFFFFFB}},
    '{1, 32'd5,          32'd0,        {DIV0_QUOT,    32'h00000005}},
    '{1, 32'd100,        32'd7,        {32'h0000000E, 32'h00000002}}
  };

  logic           clk = 1'b0;
  int             cyc = 0;
  int             checks = 0;
  int             errors = 0;

  logic           rst   [2];
  logic           a_vld [2];
  logic           b_vld [2];
  logic [W-1:0]   a_dat [2];
  logic [W-1:0]   b_dat [2];
  logic           a_rdy [2];
  logic           b_rdy [2];
  logic           o_vld [2];
  logic [2*W-1:0] o_dat [2];

  exp_t sb0[$];
  exp_t sb1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  radix2_divider #(.SIGNED(0), .WIDTH(W)) u_divu (
    .clk(clk), .reset(rst[0]),
    .s_axis_dividend_tvalid(a_vld[0]), .s_axis_dividend_tdata(a_dat[0]), .s_axis_dividend_tready(a_rdy[0]),
    .s_axis_divisor_tvalid(b_vld[0]),  .s_axis_divisor_tdata(b_dat[0]),  .s_axis_divisor_tready(b_rdy[0]),
    .m_axis_dout_tvalid(o_vld[0]),     .m_axis_dout_tdata(o_dat[0])
  );

  radix2_divider #(.SIGNED(1), .WIDTH(W)) u_div (
    .clk(clk), .reset(rst[1]),
    .s_axis_dividend_tvalid(a_vld[1]), .s_axis_dividend_tdata(a_dat[1]), .s_axis_dividend_tready(a_rdy[1]),
    .s_axis_divisor_tvalid(b_vld[1]),  .s_axis_divisor_tdata(b_dat[1]),  .s_axis_divisor_tready(b_rdy[1]),
    .m_axis_dout_tvalid(o_vld[1]),     .m_axis_dout_tdata(o_dat[1])
  );

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push(int u, logic [2*W-1:0] d, int c);
    exp_t e;
    e.data = d;
    e.cyc  = c;
    if (u == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endtask

  function automatic int sb_size(int u);
    return (u == 0) ? sb0.size() : sb1.size();
  endfunction

  task automatic mon(int u);
    exp_t e;
    if (o_vld[u] !== 1'b1) return;
    if (sb_size(u) == 0) begin
      checks++;
      errors++;
      $display("FAIL u%0d_unexpected_result actual=%h required=no_pulse", u, o_dat[u]);
      return;
    end
    if (u == 0) e = sb0.pop_front();
    else        e = sb1.pop_front();
    check($sformatf("u%0d_result", u), o_dat[u], e.data);
    check($sformatf("u%0d_latency", u), cyc - e.cyc, LAT);
  endtask

  // Monitor: compares every output pulse against the oldest queued expectation
  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  function automatic logic [2*W-1:0] ref_div(int u, logic [W-1:0] a, logic [W-1:0] b);
    logic signed [W-1:0] sa, sb;
    logic [W-1:0] q, r;
    if (u == 0) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = a;
      sb = b;
      q  = sa / sb;
      r  = sa % sb;
    end
    return {q, r};
  endfunction

  task automatic do_op(int u, logic [W-1:0] a, logic [W-1:0] b, logic [2*W-1:0] exp);
    int n = 0;
    @(negedge clk);
    while (!a_rdy[u] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!a_rdy[u]) begin
      checks++;
      errors++;
      $display("FAIL u%0d_ready_timeout actual=0 required=1", u);
      return;
    end
    a_dat[u] = a;
    b_dat[u] = b;
    a_vld[u] = 1'b1;
    b_vld[u] = 1'b1;
    @(posedge clk);
    #1;
    push(u, exp, cyc);
    a_vld[u] = 1'b0;
    b_vld[u] = 1'b0;
    a_dat[u] = $urandom();
    b_dat[u] = $urandom();
  endtask

  task automatic drain(int u);
    int n = 0;
    while (sb_size(u) != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check($sformatf("u%0d_drain", u), sb_size(u), 0);
  endtask

  task automatic rand_ops(int u, int count);
    logic [W-1:0] a, b;
    for (int i = 0; i < count; i++) begin
      a = $urandom();
      b = ($urandom_range(0, 1) == 1) ? $urandom() : W'($urandom_range(1, 100));
      if ($urandom_range(0, 3) == 0) b = -b;
      if (b == '0) b = 1;
      if (u == 1 && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 1;
      do_op(u, a, b, ref_div(u, a, b));
    end
  endtask

  initial begin
    int k;
    for (int u = 0; u < 2; u++) begin
      rst[u]   = 1'b1;
      a_vld[u] = 1'b0;
      b_vld[u] = 1'b0;
      a_dat[u] = '0;
      b_dat[u] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      check($sformatf("u%0d_reset_a_tready", u), a_rdy[u], 1);
      check($sformatf("u%0d_reset_b_tready", u), b_rdy[u], 1);
      check($sformatf("u%0d_reset_tvalid", u), o_vld[u], 0);
      check($sformatf("u%0d_reset_tdata", u), o_dat[u], 0);
    end
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // Directed vectors
    foreach (vecs[i]) do_op(vecs[i].u, vecs[i].a, vecs[i].b, vecs[i].exp);
    drain(0);
    drain(1);

    // Only the dividend offered: nothing may be accepted
    @(negedge clk);
    a_dat[0] = 32'd50;
    a_vld[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("half_valid_tready", {a_rdy[0], b_rdy[0]}, 2'b11);
    end
    a_vld[0] = 1'b0;
    repeat (40) @(posedge clk);

    // Both valids held: back-to-back accepts W+2 cycles apart
    @(negedge clk);
    a_dat[1] = 32'hFFFFFFF9;
    b_dat[1] = 32'hFFFFFFFE;
    a_vld[1] = 1'b1;
    b_vld[1] = 1'b1;
    @(posedge clk);
    #1;
    k = cyc;
    push(1, {32'h00000003, 32'hFFFFFFFF}, k);
    push(1, {32'h00000003, 32'hFFFFFFFF}, k + W + 2);
    for (int i = 0; i < W + 2; i++) begin
      check("held_tready", a_rdy[1], (i == W + 1) ? 1 : 0);
      if (i < W + 1) begin
        @(posedge clk);
        #1;
      end
    end
    @(posedge clk);
    #1;
    a_vld[1] = 1'b0;
    b_vld[1] = 1'b0;
    drain(1);

    // Abort mid-operation, then reset with valid operands
    @(negedge clk);
    a_dat[0] = 32'd100;
    b_dat[0] = 32'd7;
    a_vld[0] = 1'b1;
    b_vld[0] = 1'b1;
    @(posedge clk);
    #1;
    a_vld[0] = 1'b0;
    b_vld[0] = 1'b0;
    check("abort_busy_tready", a_rdy[0], 0);
    repeat (9) @(posedge clk);
    #1;
    rst[0] = 1'b1;
    a_vld[0] = 1'b1;
    b_vld[0] = 1'b1;
    @(posedge clk);
    #1;
    check("abort_tvalid", o_vld[0], 0);
    check("abort_tdata", o_dat[0], 0);
    check("abort_tready", a_rdy[0], 1);
    @(posedge clk);
    #1;
    rst[0]   = 1'b0;
    a_vld[0] = 1'b0;
    b_vld[0] = 1'b0;
    repeat (45) @(posedge clk);
    #1;
    check("abort_tdata_hold", o_dat[0], 0);
    do_op(0, 32'd9, 32'd3, {32'd3, 32'd0});
    drain(0);

    // Random operands against the reference model, both units concurrently
    fork
      rand_ops(0, 400);
      rand_ops(1, 400);
    join
    drain(0);
    drain(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
